bcd_div11_seq: RTL

//   Serial front-end and sequencer for the divisible-by-11 BCD check. Accepts a frame of
//   NUM_DIGITS BCD digits, MSB digit first, one per valid/ready transfer, and computes the

---
 rtl/bcd_div11_seq.sv | 91 +++++++++
 1 files changed

// File: rtl/bcd_div11_seq.sv
// rtl/bcd_div11_seq.sv - serial BCD frame loader computing the frame value mod 11
module bcd_div11_seq #(
    parameter int NUM_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic       busy,
    output logic       done,
    output logic       divisible,
    output logic [3:0] remainder,
    output logic       bcd_err
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, REPORT} state_t;

    state_t        state;
    logic [3:0]    acc;
    logic [CW-1:0] count;
    logic          err_acc;

    logic       digit_bad;
    logic [3:0] digit_eff;
    logic [4:0] sum;
    logic [3:0] acc_next;
    logic       err_next;
    logic       transfer;

    // Shifting in a digit multiplies by 10 == -1 mod 11, so acc' = digit - acc.
    always_comb begin
        digit_bad = (digit_in > 4'd9);
        digit_eff = digit_bad ? (digit_in & 4'h7) : digit_in;
        sum       = {1'b0, digit_eff} + 5'd11 - {1'b0, acc};
        if (sum >= 5'd11) acc_next = 4'(sum - 5'd11);
        else              acc_next = sum[3:0];
        err_next  = err_acc | digit_bad;
        transfer  = digit_valid & (state == LOAD) & ~abort;
    end

    assign digit_ready = (state == LOAD);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 4'd0;
            count     <= '0;
            err_acc   <= 1'b0;
            done      <= 1'b0;
            divisible <= 1'b0;
            remainder <= 4'd0;
            bcd_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        acc     <= 4'd0;
                        count   <= '0;
                        err_acc <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (transfer) begin
                        acc     <= acc_next;
                        err_acc <= err_next;
                        count   <= count + CW'(1);
                        if (count == LAST) begin
                            state     <= REPORT;
                            remainder <= acc_next;
                            bcd_err   <= err_next;
                            divisible <= (acc_next == 4'd0) & ~err_next;
                            done      <= 1'b1;
                        end
                    end
                end
                REPORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
